// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight: IDLE grants and latches operands, EXEC captures the ALU, RESP holds the response.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic             rsp_z,
  output logic [2:0]       alu_gsel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [2:0]       alu_gsel_q, alu_gsel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_c_q, rsp_c_d;
  logic             rsp_v_q, rsp_v_d;
  logic             rsp_z_q, rsp_z_d;
  logic             sel;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    alu_gsel_d   = alu_gsel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_result_d = rsp_result_q;
    rsp_c_d      = rsp_c_q;
    rsp_v_d      = rsp_v_q;
    rsp_z_d      = rsp_z_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    sel          = ptr_q;

    case (state_q)
      IDLE: begin
        // Pointer only breaks ties; a lone requester always wins. No grant while rst holds the state.
        if ((req0_valid || req1_valid) && !rst) begin
          sel        = (req0_valid && req1_valid) ? ptr_q : req1_valid;
          req0_ready = !sel;
          req1_ready = sel;
          gnt_d      = sel;
          alu_gsel_d = sel ? req1_op : req0_op;
          alu_a_d    = sel ? req1_a : req0_a;
          alu_b_d    = sel ? req1_b : req0_b;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_c_d      = alu_c;
        rsp_v_d      = alu_v;
        rsp_z_d      = (alu_result == '0);
        state_d      = RESP;
      end
      RESP: begin
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          ptr_d   = !gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      alu_gsel_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_c_q      <= 1'b0;
      rsp_v_q      <= 1'b0;
      rsp_z_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      alu_gsel_q   <= alu_gsel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_q      <= rsp_c_d;
      rsp_v_q      <= rsp_v_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !gnt_q;
  assign rsp1_valid = (state_q == RESP) && gnt_q;
  assign busy       = (state_q != IDLE);
  assign alu_gsel   = alu_gsel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_v      = rsp_v_q;
  assign rsp_z      = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU: gsel[2:1]=00 add/sub (gsel[0]), 01 and, 10 or, 11 xor.
module tb_alu_arbiter;

  logic        clk, rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_c, rsp_v, rsp_z;
  logic [2:0]  alu_gsel;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_c, alu_v, busy;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        c, v, z;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z),
    .alu_gsel(alu_gsel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [31:0] bb;
    bb         = alu_gsel[0] ? ~alu_b : alu_b;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_result = '0;
    case (alu_gsel[2:1])
      2'b00: begin
        {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, bb} + {32'd0, alu_gsel[0]};
        alu_v = (alu_a[31] == bb[31]) && (alu_result[31] != alu_a[31]);
      end
      2'b01:   alu_result = alu_a & alu_b;
      2'b10:   alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic [31:0] r, input logic c, input logic v, input logic z);
    exp_t e;
    e.port = p; e.res = r; e.c = c; e.v = v; e.z = z;
    sb.push_back(e);
  endtask

  // Monitor: compares at every completed response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid && rsp1_valid) chk1("rsp_both_valid", 1'b1, 1'b0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          chk1("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk1("rsp_port", rsp1_valid, e.port);
          chk("rsp_result", rsp_result, e.res);
          chk1("rsp_c", rsp_c, e.c);
          chk1("rsp_v", rsp_v, e.v);
          chk1("rsp_z", rsp_z, e.z);
        end
      end
    end
  end

  // Drive one request from posedge+1 and hold it until granted.
  task automatic send(input logic p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if (p) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 30; i++) begin
      #1;
      if (p ? req1_ready : req0_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk1("grant_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk1("idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, last;
    bit got;
    rst = 1;
    req0_valid = 0; req1_valid = 0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk1("rst_rsp_z", rsp_z, 1'b1);
    chk("rst_alu_a", alu_a, 32'd0);
    rst = 0;

    // Single add on req0: latency and handshake timing.
    push(1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b000, 32'd5, 32'd7);
    chk1("exec_busy", busy, 1'b1);
    chk1("exec_req0_ready", req0_ready, 1'b0);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd7);
    chk("exec_alu_gsel", {29'd0, alu_gsel}, 32'd0);
    @(posedge clk); #1;
    chk1("resp_rsp0_valid", rsp0_valid, 1'b1);
    chk1("resp_rsp1_valid", rsp1_valid, 1'b0);
    @(posedge clk); #1;
    chk1("done_busy", busy, 1'b0);
    chk1("done_rsp0_valid", rsp0_valid, 1'b0);

    // Subtract to zero on req1.
    push(1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    send(1'b1, 3'b001, 32'h1234, 32'h1234);
    wait_idle();

    // Contention: pointer is 0 here, so grants go 0,1,0,1 three cycles apart.
    push(1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
    push(1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
    push(1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
    push(1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_op = 3'b000; req0_a = 32'd1;  req0_b = 32'd2;
    req1_op = 3'b000; req1_a = 32'd10; req1_b = 32'd20;
    req0_valid = 1; req1_valid = 1;
    n = 0; last = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk1("cont_grant_port", req1_ready, n[0]);
        if (n > 0) chk("cont_grant_spacing", cyc - last, 32'd3);
        last = cyc;
        n++;
        if (n == 4) break;
      end
      @(posedge clk); #1;
    end
    if (n != 4) chk("cont_grant_count", n, 32'd4);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_idle();

    // Signed overflow.
    push(1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send(1'b0, 3'b000, 32'h7FFF_FFFF, 32'd1);
    wait_idle();

    // Backpressure on rsp0 with req1 pending.
    rsp0_ready = 0;
    push(1'b0, 32'd123, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b000, 32'd100, 32'd23);
    req1_op = 3'b000; req1_a = 32'd2; req1_b = 32'd2; req1_valid = 1;
    push(1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
    #1 chk1("bp_exec_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_rsp_result", rsp_result, 32'd123);
      chk1("bp_req1_ready", req1_ready, 1'b0);
      chk1("bp_busy", busy, 1'b1);
      chk("bp_alu_a", alu_a, 32'd100);
      @(posedge clk); #1;
    end
    rsp0_ready = 1;
    @(posedge clk); #1;
    #1;
    chk1("bp_release_busy", busy, 1'b0);
    chk1("bp_release_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_idle();

    // AND op on req0 leaves pointer at 1 and a nonzero response before the reset test.
    push(1'b0, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00);
    wait_idle();

    // Reset during EXEC aborts the operation; no expectation is queued for it.
    send(1'b1, 3'b000, 32'd6, 32'd6);
    #2 rst = 1;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("mid_rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_alu_gsel", {29'd0, alu_gsel}, 32'd0);
    chk("mid_rst_rsp_result", rsp_result, 32'd0);
    chk1("mid_rst_rsp_c", rsp_c, 1'b0);
    chk1("mid_rst_rsp_v", rsp_v, 1'b0);
    chk1("mid_rst_rsp_z", rsp_z, 1'b1);
    req0_op = 3'b000; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
    req1_op = 3'b101; req1_a = 32'h0000_00FF; req1_b = 32'h0000_FF00;
    req0_valid = 1; req1_valid = 1;
    @(posedge clk); #1;
    chk1("in_rst_rsp1_valid", rsp1_valid, 1'b0);
    push(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    push(1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    rst = 0;
    #1;
    chk1("post_rst_req0_ready", req0_ready, 1'b1);
    chk1("post_rst_req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req1_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) chk1("post_rst_req1_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_idle();
    repeat (2) @(posedge clk);

    chk("sb_leftover", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width; it matches the shared ALU datapath width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  operation of requester n accepted this cycle.
REQ-006 req0_op, req1_op  input  3 each  ALU G_Select code; bit0 = carry-in/subtract, bits[2:1] = result select.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  response for requester n is held.
REQ-009 rsp0_ready, rsp1_ready  input  1 each  requester n consumes its response.
REQ-010 rsp_result  output  WIDTH  response result, shared by both response channels.
REQ-011 rsp_c, rsp_v, rsp_z  output  1 each  carry, overflow and zero (result == 0) flags.
REQ-012 alu_gsel  output  3  registered G_Select driven to the ALU.
REQ-013 alu_a, alu_b  output  WIDTH each  registered operands driven to the ALU.
REQ-014 alu_result  input  WIDTH; alu_c, alu_v  input  1 each  combinational ALU outputs.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-017 IDLE: when at least one reqN_valid is high, the block SHALL assert exactly one reqN_ready combinationally in the same cycle, latch that requester's op/a/b into alu_gsel/alu_a/alu_b, record the grant index and go to EXEC.
REQ-018 Arbitration SHALL be round-robin using a 1-bit priority pointer.
  - With both valid, the requester selected by the pointer wins.
  - With one valid, that requester wins regardless of the pointer.
REQ-019 The pointer SHALL update only on response completion, to the requester that was not just served.
REQ-020 EXEC: lasts exactly one cycle. The block SHALL capture alu_result, alu_c, alu_v and (alu_result == 0) into the response registers, then go to RESP.
REQ-021 RESP: rspN_valid SHALL be high only for the granted N. On a cycle with rspN_valid && rspN_ready, the block SHALL drop rspN_valid on the next edge and return to IDLE.
REQ-022 reqN_ready SHALL be low in EXEC and RESP; no request is accepted while busy (non-pipelined, one operation in flight).
REQ-023 Minimum latency: request accepted in cycle T -> rspN_valid high in cycle T+2. Back-to-back throughput SHALL be one operation per 3 cycles when rspN_ready is held high.
REQ-024 rsp_result/rsp_c/rsp_v/rsp_z SHALL stay stable while either rspN_valid is high; alu_* outputs SHALL stay stable from IDLE exit until the next grant.
REQ-025 Requesters SHALL hold reqN_valid and operands stable until reqN_ready; the block does not check this.
REQ-026 A requester dropping reqN_valid before it is granted SHALL lose no state and cause no grant.
REQ-027 Response rules:
  - rspN_ready asserted while rspN_valid is low SHALL be ignored.
  - rspN_ready held high across the EXEC->RESP edge SHALL complete the response in its first RESP cycle.
REQ-028 Arithmetic is performed by the external ALU. The block SHALL pass op and operands unmodified and compute only rsp_z, over all WIDTH bits.

Reset
REQ-029 On rst high, the block SHALL immediately (asynchronously) reset:
  - state to IDLE and pointer to 0 (requester 0 preferred);
  - alu_gsel, alu_a, alu_b, rsp_result, rsp_c, rsp_v to 0, and rsp_z to 1;
  - rsp0_valid, rsp1_valid and busy to 0.
REQ-030 rst asserted during EXEC or RESP SHALL abort the in-flight operation without emitting a response; the first grant after rst release follows REQ-018 with pointer 0.

Verification
REQ-031 Single op: req0 op=000, a=5, b=7 in cycle T -> req0_ready at T; rsp0_valid at T+2 with result=12, c=0, v=0, z=0.
REQ-032 Subtract to zero: req1 op=001, a=b=0x1234 -> rsp1_valid with result=0, z=1, c=1 (no borrow), v=0.
REQ-033 Contention: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1, one grant every 3 cycles.
REQ-034 Overflow: op=000, a=0x7FFFFFFF, b=1 -> result=0x80000000, v=1, c=0.
REQ-035 Backpressure: rsp0_ready low for 5 cycles -> rsp0_valid and rsp_result stay stable, req1_ready stays low, busy stays 1; raising rsp0_ready -> IDLE on the next edge.
REQ-036 Reset mid-op: rst pulsed in EXEC -> no rsp*_valid, all outputs at reset values; pending req1 and req0 then both valid -> req0 granted first.
